// File: rtl/wiener_pkg.sv
// rtl/wiener_pkg.sv - shared constants for the 3x3 window producer and its consumers
package wiener_pkg;

    localparam int PIX_W = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    // Window taps are row-major, p0 top-left .. p8 bottom-right
    localparam int WIN_TAPS   = 9;
    localparam int WIN_CENTRE = 4;

endpackage

// File: rtl/line_buf.sv
// rtl/line_buf.sv - one-line pixel store, async read, sync write, contents not reset
module line_buf #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/window3x3_gen.sv
// rtl/window3x3_gen.sv - raster pixels in, fully interior 3x3 windows out
// Optional WIN3X3_COORD_EN adds out_row/out_col (window centre coordinate).
module window3x3_gen
    import wiener_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int DATA_W = PIX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] p0,
    output logic [DATA_W-1:0] p1,
    output logic [DATA_W-1:0] p2,
    output logic [DATA_W-1:0] p3,
    output logic [DATA_W-1:0] p4,
    output logic [DATA_W-1:0] p5,
    output logic [DATA_W-1:0] p6,
    output logic [DATA_W-1:0] p7,
    output logic [DATA_W-1:0] p8,
    output logic              out_sof,
    output logic              out_eof,
    output logic              out_valid,
`ifdef WIN3X3_COORD_EN
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic [$clog2(IMG_W)-1:0] out_col,
`endif
    input  logic              out_ready
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

    logic [1:0]        state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d, eff_row;
    logic [COL_W-1:0]  col_q, col_d, eff_col;
    logic              accept, take, col_last, row_last, win_load;
    logic [DATA_W-1:0] lb0_rd, lb1_rd;
    logic [DATA_W-1:0] sh_q [WIN_TAPS];
    logic [DATA_W-1:0] sh_d [WIN_TAPS];
    logic [DATA_W-1:0] p_q  [WIN_TAPS];
    logic [DATA_W-1:0] p_d  [WIN_TAPS];
    logic              out_valid_q, out_valid_d;
    logic              out_sof_q, out_sof_d;
    logic              out_eof_q, out_eof_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // Outside IDLE every accepted pixel is stored; in IDLE only a frame start is
    assign take     = accept && (in_sof || state_q != S_IDLE);

    // A frame start always lands at (0,0), aborting any frame in progress
    assign eff_row  = in_sof ? '0 : row_q;
    assign eff_col  = in_sof ? '0 : col_q;
    assign col_last = (eff_col == LAST_COL);
    assign row_last = (eff_row == LAST_ROW);
    assign win_load = take && !in_sof && (state_q == S_RUN) && (col_q >= COL_W'(2));

    line_buf #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb0 (
        .clk   (clk),
        .we    (take),
        .waddr (eff_col),
        .wdata (in_data),
        .raddr (eff_col),
        .rdata (lb0_rd)
    );

    line_buf #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
        .clk   (clk),
        .we    (take),
        .waddr (eff_col),
        .wdata (lb0_rd),
        .raddr (eff_col),
        .rdata (lb1_rd)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        if (take) begin
            col_d = col_last ? '0 : eff_col + COL_W'(1);
            if (col_last) begin
                row_d = row_last ? '0 : eff_row + ROW_W'(1);
            end else begin
                row_d = eff_row;
            end
            case (in_sof ? S_FILL : state_q)
                S_FILL:  state_d = (eff_row == ROW_W'(1) && col_last) ? S_RUN : S_FILL;
                S_RUN:   state_d = (row_last && col_last) ? S_IDLE : S_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    // New column enters on the right: top from LB1, middle from LB0, bottom is the live pixel
    always_comb begin
        for (int i = 0; i < WIN_TAPS; i++) begin
            sh_d[i] = sh_q[i];
        end
        if (take) begin
            for (int k = 0; k < 3; k++) begin
                sh_d[3*k]     = sh_q[3*k+1];
                sh_d[3*k + 1] = sh_q[3*k+2];
            end
            sh_d[2] = lb1_rd;
            sh_d[5] = lb0_rd;
            sh_d[8] = in_data;
        end
    end

    always_comb begin
        for (int i = 0; i < WIN_TAPS; i++) begin
            p_d[i] = p_q[i];
        end
        out_valid_d = out_valid_q && !out_ready;
        out_sof_d   = out_sof_q && out_valid_d;
        out_eof_d   = out_eof_q && out_valid_d;
        if (win_load) begin
            for (int i = 0; i < WIN_TAPS; i++) begin
                p_d[i] = sh_d[i];
            end
            out_valid_d = 1'b1;
            out_sof_d   = (row_q == ROW_W'(2)) && (col_q == COL_W'(2));
            out_eof_d   = (row_q == LAST_ROW) && (col_q == LAST_COL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            for (int i = 0; i < WIN_TAPS; i++) begin
                sh_q[i] <= '0;
                p_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            for (int i = 0; i < WIN_TAPS; i++) begin
                sh_q[i] <= sh_d[i];
                p_q[i]  <= p_d[i];
            end
        end
    end

`ifdef WIN3X3_COORD_EN
    logic [ROW_W-1:0] out_row_q;
    logic [COL_W-1:0] out_col_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_row_q <= '0;
            out_col_q <= '0;
        end else if (win_load) begin
            out_row_q <= row_q - ROW_W'(1);
            out_col_q <= col_q - COL_W'(1);
        end
    end

    assign out_row = out_row_q;
    assign out_col = out_col_q;
`endif

    assign p0        = p_q[0];
    assign p1        = p_q[1];
    assign p2        = p_q[2];
    assign p3        = p_q[3];
    assign p4        = p_q[WIN_CENTRE];
    assign p5        = p_q[5];
    assign p6        = p_q[6];
    assign p7        = p_q[7];
    assign p8        = p_q[8];
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign out_valid = out_valid_q;

endmodule
